uart_tx_scheduler: RTL

Round-robin scheduler that shares one UART_TX transmitter among `N_REQ` byte producers. It arbitrates pending requests, presents the winner's byte to UART_TX with a single-cycle `send` pulse, then holds off further grants for one full frame time, since UART_TX exposes no busy indication. Sits between the producer blocks and the UART_TX `send`/`data` inputs, on the same clock.

---
 rtl/uart_tx_scheduler.sv | 113 +++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART_TX among N_REQ byte producers.
// Issues a one-cycle send per grant, then blocks further grants for a frame plus gap.
module uart_tx_scheduler #(
  parameter int N_REQ        = 4,
  parameter int FRAME_CYCLES = 80,
  parameter int GAP_CYCLES   = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         ack,
  output logic                     tx_send,
  output logic [7:0]               tx_data,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy
);

  localparam int TOTAL = FRAME_CYCLES + GAP_CYCLES;
  localparam int CNT_W = $clog2(TOTAL);
  localparam int ID_W  = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TOTAL - 2);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t           state_r;
  logic [ID_W-1:0]  ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic [ID_W-1:0]  win_s;
  logic             win_valid_s;

  // Winner search: first requesting index at or above ptr_r, wrapping modulo N_REQ.
  always_comb begin
    logic [ID_W:0]   sum_s;
    logic [ID_W-1:0] idx_s;
    sum_s       = '0;
    idx_s       = '0;
    win_s       = '0;
    win_valid_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      sum_s = {1'b0, ptr_r} + (ID_W+1)'(i);
      if (sum_s >= (ID_W+1)'(N_REQ)) begin
        idx_s = ID_W'(sum_s - (ID_W+1)'(N_REQ));
      end else begin
        idx_s = sum_s[ID_W-1:0];
      end
      if (!win_valid_s && req[idx_s]) begin
        win_valid_s = 1'b1;
        win_s       = idx_s;
      end else begin
        win_valid_s = win_valid_s;
      end
    end
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      ptr_r    <= '0;
      cnt_r    <= '0;
      ack      <= '0;
      tx_send  <= 1'b0;
      tx_data  <= 8'h00;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (win_valid_s) begin
            state_r  <= SEND;
            tx_data  <= req_data[{win_s, 3'b000} +: 8];
            grant_id <= win_s;
            ack      <= {{(N_REQ-1){1'b0}}, 1'b1} << win_s;
            tx_send  <= 1'b1;
            busy     <= 1'b1;
            ptr_r    <= (win_s == LAST_ID) ? '0 : win_s + ID_W'(1);
            cnt_r    <= CNT_LOAD;
          end else begin
            state_r <= IDLE;
          end
        end
        SEND: begin
          state_r <= WAIT;
          tx_send <= 1'b0;
          ack     <= '0;
        end
        WAIT: begin
          // busy falls on the same edge that returns to IDLE, giving TOTAL busy cycles
          if (cnt_r == '0) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          tx_send <= 1'b0;
          ack     <= '0;
          busy    <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule
